neuron_mac_sequencer: RTL and testbench

- Computes one neuron output: result = act(Σ input[k]·weight[k] + bias), k = 0..N-1.
- Sequences a single shared signed_fixed_point_multiplier instance over N operand pairs fetched from input and weight memories, accumulates the products, adds bias, saturates and optionally applies ReLU.
- Sits between the layer controller (start/done handshake) and the activation/weight RAMs.

---
 rtl/nn_fixed_pkg.sv | 24 ++
 rtl/signed_fixed_point_multiplier.sv | 52 +++++
 rtl/neuron_mac_sequencer.sv | 162 ++++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point types, constants and sequencer state encoding for the neuron datapath.
package nn_fixed_pkg;

  localparam int unsigned FIXED_POINT_LENGTH_DEFAULT   = 16;
  localparam int unsigned FIXED_POINT_POSITION_DEFAULT = 10;

  localparam int unsigned MULT_LATENCY = 2;
  localparam int unsigned RAM_LATENCY  = 1;
  localparam int unsigned PIPE_DEPTH   = RAM_LATENCY + MULT_LATENCY;

  typedef logic signed [FIXED_POINT_LENGTH_DEFAULT-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_POINT_LENGTH_DEFAULT-1){1'b1}}};
  localparam fixed_t FIXED_MIN = {1'b1, {(FIXED_POINT_LENGTH_DEFAULT-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    BIAS  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/signed_fixed_point_multiplier.sv
// Two-stage signed fixed-point multiplier: full product, then arithmetic shift
// by the fractional width and saturation back to the operand width.
module signed_fixed_point_multiplier
  import nn_fixed_pkg::*;
#(
  parameter int unsigned FIXED_POINT_LENGTH   = FIXED_POINT_LENGTH_DEFAULT,
  parameter int unsigned FIXED_POINT_POSITION = FIXED_POINT_POSITION_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FIXED_POINT_LENGTH-1:0] a_in,
  input  logic [FIXED_POINT_LENGTH-1:0] b_in,
  output logic [FIXED_POINT_LENGTH-1:0] product_out
);

  localparam int unsigned FL     = FIXED_POINT_LENGTH;
  localparam int unsigned PROD_W = 2 * FL;

  localparam logic signed [PROD_W-1:0] P_MAX = {{(PROD_W-FL+1){1'b0}}, {(FL-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] P_MIN = {{(PROD_W-FL+1){1'b1}}, {(FL-1){1'b0}}};

  logic signed [PROD_W-1:0] a_ext_c;
  logic signed [PROD_W-1:0] b_ext_c;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] shifted_c;
  logic        [FL-1:0]     sat_c;

  assign a_ext_c   = PROD_W'($signed(a_in));
  assign b_ext_c   = PROD_W'($signed(b_in));
  assign shifted_c = prod_q >>> FIXED_POINT_POSITION;

  // Clip the rescaled product into the representable Q range
  always_comb begin
    sat_c = FL'(shifted_c);
    if (shifted_c > P_MAX) begin
      sat_c = FL'(P_MAX);
    end else if (shifted_c < P_MIN) begin
      sat_c = FL'(P_MIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q      <= '0;
      product_out <= '0;
    end else begin
      prod_q      <= a_ext_c * b_ext_c;
      product_out <= sat_c;
    end
  end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sequences one shared multiplier over N input/weight pairs, accumulates,
// adds bias, saturates and optionally applies ReLU to produce one neuron output.
module neuron_mac_sequencer
  import nn_fixed_pkg::*;
#(
  parameter int unsigned FIXED_POINT_LENGTH   = FIXED_POINT_LENGTH_DEFAULT,
  parameter int unsigned FIXED_POINT_POSITION = FIXED_POINT_POSITION_DEFAULT,
  parameter int unsigned MAX_INPUTS           = 64,
  parameter int unsigned ADDR_WIDTH           = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            start_in,
  input  logic [$clog2(MAX_INPUTS):0]     num_inputs_in,
  input  logic [ADDR_WIDTH-1:0]           weight_base_in,
  input  logic [FIXED_POINT_LENGTH-1:0]   bias_in,
  input  logic                            relu_en_in,
  output logic [ADDR_WIDTH-1:0]           input_addr_out,
  output logic [ADDR_WIDTH-1:0]           weight_addr_out,
  input  logic [FIXED_POINT_LENGTH-1:0]   input_data_in,
  input  logic [FIXED_POINT_LENGTH-1:0]   weight_data_in,
  output logic                            busy_out,
  output logic                            done_out,
  output logic [FIXED_POINT_LENGTH-1:0]   result_out,
  output logic                            saturated_out
);

  localparam int unsigned FL    = FIXED_POINT_LENGTH;
  localparam int unsigned CNT_W = $clog2(MAX_INPUTS) + 1;
  localparam int unsigned ACC_W = FL + $clog2(MAX_INPUTS) + 1;
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-FL+1){1'b0}}, {(FL-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-FL+1){1'b1}}, {(FL-1){1'b0}}};

  state_t                   state_q;
  state_t                   state_d;
  logic [CNT_W-1:0]         n_q;
  logic [CNT_W-1:0]         k_q;
  logic [CNT_W-1:0]         n_clamped_c;
  logic                     last_fetch_c;
  logic [1:0]               drain_cnt_q;
  logic signed [FL-1:0]     bias_q;
  logic                     relu_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [PIPE_DEPTH-1:0]    vld_q;
  logic [FL-1:0]            product_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic [FL-1:0]            clip_c;
  logic [FL-1:0]            res_c;
  logic                     sat_c;

  assign n_clamped_c  = (num_inputs_in > CNT_W'(MAX_INPUTS)) ? CNT_W'(MAX_INPUTS) : num_inputs_in;
  assign last_fetch_c = (k_q == n_q - CNT_W'(1));

  signed_fixed_point_multiplier #(
    .FIXED_POINT_LENGTH   (FIXED_POINT_LENGTH),
    .FIXED_POINT_POSITION (FIXED_POINT_POSITION)
  ) u_mult (
    .clk         (clk_in),
    .rst_n       (rst_n_in),
    .a_in        (input_data_in),
    .b_in        (weight_data_in),
    .product_out (product_c)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_in) state_d = (n_clamped_c != '0) ? FETCH : DRAIN;
      FETCH:   if (last_fetch_c) state_d = DRAIN;
      DRAIN:   if (drain_cnt_q == 2'd2) state_d = BIAS;
      BIAS:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final sum: bias add, clip to Q range, then optional ReLU on the clipped value
  always_comb begin
    sum_c  = SUM_W'(acc_q) + SUM_W'(bias_q);
    sat_c  = 1'b0;
    clip_c = FL'(sum_c);
    if (sum_c > SUM_MAX) begin
      clip_c = FL'(SUM_MAX);
      sat_c  = 1'b1;
    end else if (sum_c < SUM_MIN) begin
      clip_c = FL'(SUM_MIN);
      sat_c  = 1'b1;
    end
    res_c = clip_c;
    if (relu_q && clip_c[FL-1]) begin
      res_c = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      n_q             <= '0;
      k_q             <= '0;
      drain_cnt_q     <= '0;
      bias_q          <= '0;
      relu_q          <= 1'b0;
      acc_q           <= '0;
      vld_q           <= '0;
      input_addr_out  <= '0;
      weight_addr_out <= '0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      result_out      <= '0;
      saturated_out   <= 1'b0;
    end else begin
      busy_out <= (state_d != IDLE);
      done_out <= (state_d == DONE);
      // Each tag marks a product that reaches the accumulator RAM+multiplier latency later
      vld_q    <= {vld_q[PIPE_DEPTH-2:0], (state_q == FETCH)};
      if (vld_q[PIPE_DEPTH-1]) begin
        acc_q <= acc_q + ACC_W'($signed(product_c));
      end
      case (state_q)
        IDLE: begin
          if (start_in) begin
            n_q         <= n_clamped_c;
            bias_q      <= bias_in;
            relu_q      <= relu_en_in;
            acc_q       <= '0;
            k_q         <= '0;
            drain_cnt_q <= '0;
            if (n_clamped_c != '0) begin
              input_addr_out  <= '0;
              weight_addr_out <= weight_base_in;
            end
          end
        end
        FETCH: begin
          k_q <= k_q + CNT_W'(1);
          if (!last_fetch_c) begin
            input_addr_out  <= input_addr_out + ADDR_WIDTH'(1);
            weight_addr_out <= weight_addr_out + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 2'd1;
        end
        BIAS: begin
          result_out    <= res_c;
          saturated_out <= sat_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench for neuron_mac_sequencer: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done_out pulses.
module tb_neuron_mac_sequencer;
  import nn_fixed_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n_in;
  logic         start_in;
  logic [6:0]   num_inputs_in;
  logic [7:0]   weight_base_in;
  logic [15:0]  bias_in;
  logic         relu_en_in;
  logic [7:0]   input_addr_out;
  logic [7:0]   weight_addr_out;
  fixed_t       input_data_in;
  fixed_t       weight_data_in;
  logic         busy_out;
  logic         done_out;
  logic [15:0]  result_out;
  logic         saturated_out;

  fixed_t       input_mem  [0:255];
  fixed_t       weight_mem [0:255];

  typedef struct {
    logic [15:0] res;
    logic        sat;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t         exp_q[$];
  int unsigned  cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic         prev_done = 1'b0;
  logic         found;

  neuron_mac_sequencer dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .num_inputs_in   (num_inputs_in),
    .weight_base_in  (weight_base_in),
    .bias_in         (bias_in),
    .relu_en_in      (relu_en_in),
    .input_addr_out  (input_addr_out),
    .weight_addr_out (weight_addr_out),
    .input_data_in   (input_data_in),
    .weight_data_in  (weight_data_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .result_out      (result_out),
    .saturated_out   (saturated_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM models with one cycle of latency
  always @(posedge clk) begin
    input_data_in  <= input_mem[input_addr_out];
    weight_data_in <= weight_mem[weight_addr_out];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (prev_done) check("done_pulse_width", 32'(done_out), 32'd0);
    if (done_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: result 0x%0h with no run pending", result_out);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"},  32'(result_out),    32'(e.res));
        check({e.name, "_sat"},     32'(saturated_out), 32'(e.sat));
        check({e.name, "_latency"}, cyc,                e.cyc);
      end
    end
    prev_done = done_out;
  end

  task automatic fill(input fixed_t iv, input fixed_t wv);
    for (int i = 0; i < 256; i++) begin
      input_mem[i]  = iv;
      weight_mem[i] = wv;
    end
  endtask

  // Issue a start and queue its expectation; returns at the first negedge after the start edge
  task automatic launch(input int n, input logic [7:0] base, input logic [15:0] bias,
                        input logic relu, input logic [15:0] er, input logic es,
                        input string name);
    exp_t e;
    int   nc;
    @(negedge clk);
    start_in       = 1'b1;
    num_inputs_in  = 7'(n);
    weight_base_in = base;
    bias_in        = bias;
    relu_en_in     = relu;
    @(posedge clk);
    #1;
    nc    = (n > 64) ? 64 : n;
    e.res = er;
    e.sat = es;
    e.cyc = cyc + 32'(nc) + 32'd4;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
    start_in       = 1'b0;
    num_inputs_in  = 7'($urandom);
    weight_base_in = 8'($urandom);
    bias_in        = 16'($urandom);
    relu_en_in     = 1'($urandom);
    check({name, "_busy"}, 32'(busy_out), 32'd1);
  endtask

  task automatic wait_done(input string name);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done_out) found = 1'b1;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: done_out not seen, expected within 200 cycles", name);
    end
  endtask

  initial begin
    rst_n_in       = 1'b0;
    start_in       = 1'b0;
    num_inputs_in  = '0;
    weight_base_in = '0;
    bias_in        = '0;
    relu_en_in     = 1'b0;
    fill(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy_out),        32'd0);
    check("rst_done",   32'(done_out),        32'd0);
    check("rst_result", 32'(result_out),      32'd0);
    check("rst_sat",    32'(saturated_out),   32'd0);
    check("rst_waddr",  32'(weight_addr_out), 32'd0);
    rst_n_in = 1'b1;

    // N=0: bias passes straight through, addresses stay at their reset value
    launch(0, 8'h55, 16'hFC00, 1'b0, 16'hFC00, 1'b0, "n0");
    check("n0_iaddr_mid", 32'(input_addr_out),  32'd0);
    wait_done("n0");
    check("n0_waddr_end", 32'(weight_addr_out), 32'd0);

    fill(16'h0400, 16'h0200);
    launch(4, 8'h00, 16'h0100, 1'b0, 16'h0900, 1'b0, "pos4");
    wait_done("pos4");

    fill(16'h0400, 16'hFE00);
    launch(4, 8'h00, 16'h0100, 1'b0, 16'hF900, 1'b0, "neg4");
    wait_done("neg4");
    launch(4, 8'h00, 16'h0100, 1'b1, 16'h0000, 1'b0, "neg4_relu");
    wait_done("neg4_relu");

    fill(16'h7FFF, 16'h7FFF);
    launch(8, 8'h00, 16'h0000, 1'b0, 16'h7FFF, 1'b1, "sat_hi");
    wait_done("sat_hi");
    fill(16'h7FFF, 16'h8000);
    launch(8, 8'h00, 16'h0000, 1'b0, 16'h8000, 1'b1, "sat_lo");
    wait_done("sat_lo");

    // N=100 clamps to 64 terms of 1.0*(1/16)
    fill(16'h0400, 16'h0040);
    launch(100, 8'h00, 16'h0000, 1'b0, 16'h1000, 1'b0, "clamp");
    wait_done("clamp");

    // Weight row wraps the address space; start pulses mid-FETCH and in DONE are ignored
    fill(16'h0000, 16'h0000);
    input_mem[0] = 16'h0400;  weight_mem[8'hFE] = 16'h0400;
    input_mem[1] = 16'h0200;  weight_mem[8'hFF] = 16'h0800;
    input_mem[2] = 16'h0100;  weight_mem[8'h00] = 16'h0C00;
    input_mem[3] = 16'h0080;  weight_mem[8'h01] = 16'h1000;
    launch(4, 8'hFE, 16'h0000, 1'b0, 16'h0D00, 1'b0, "wrap");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      start_in = (k == 1);
      check($sformatf("wrap_waddr%0d", k), 32'(weight_addr_out), 32'((8'hFE + k) & 8'hFF));
      check($sformatf("wrap_iaddr%0d", k), 32'(input_addr_out),  32'(k));
    end
    start_in = 1'b0;
    wait_done("wrap");
    start_in      = 1'b1;
    num_inputs_in = 7'd2;
    @(negedge clk);
    start_in = 1'b0;
    check("done_start_ignored", 32'(busy_out), 32'd0);
    repeat (10) @(negedge clk);
    check("done_start_still_idle", 32'(busy_out), 32'd0);

    // Reset mid-FETCH abandons the run
    fill(16'h7FFF, 16'h7FFF);
    launch(8, 8'h00, 16'h0000, 1'b0, 16'h7FFF, 1'b1, "aborted");
    repeat (2) @(negedge clk);
    void'(exp_q.pop_back());
    rst_n_in = 1'b0;
    #1;
    check("abort_busy",   32'(busy_out),   32'd0);
    check("abort_done",   32'(done_out),   32'd0);
    check("abort_result", 32'(result_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n_in = 1'b1;
    repeat (8) @(negedge clk);
    fill(16'h0400, 16'h0200);
    launch(4, 8'h00, 16'h0100, 1'b0, 16'h0900, 1'b0, "after_rst");
    wait_done("after_rst");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
